// File: rtl/uart_rx_frame_sampler.sv
// UART receive frame sampler.
// Takes over the serial line after the start-bit detector fires, samples each
// bit at mid-bit on a 16x (OVERSAMPLE) baud tick, assembles an LSB-first word,
// checks optional parity and the stop bit, and emits one-cycle result pulses.
module uart_rx_frame_sampler #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  logic                 Clk,
    input  logic                 reset_n,
    input  logic                 baud_tick_in,
    input  logic                 rx_in,
    input  logic                 start_bit_in,
    output logic                 startbit_det_enable_out,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid_out,
    output logic                 parity_err_out,
    output logic                 framing_err_out,
    output logic                 busy_out
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    // Tick-count values at which the sampling tick is the one currently present.
    localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        START      = 3'd1,
        DATA       = 3'd2,
        PARITY     = 3'd3,
        STOP       = 3'd4,
        BREAK_WAIT = 3'd5
    } state_t;

    state_t               r_state;
    logic [TW-1:0]        r_tick_cnt;
    logic [BW-1:0]        r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_err;
    logic                 r_rx_meta;
    logic                 r_rx_s;

    logic                 r_en;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_valid;
    logic                 r_perr;
    logic                 r_ferr;
    logic                 r_busy;

    logic                 w_half_hit;
    logic                 w_full_hit;
    logic                 w_par_exp;
    logic                 w_par_mismatch;

    // Two-flop synchroniser; preset high so reset looks like an idle line.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= rx_in;
            r_rx_s    <= r_rx_meta;
        end
    end

    // Sampling points: mid start bit, then every full bit period after that.
    assign w_half_hit     = baud_tick_in && (r_tick_cnt == HALF_LAST);
    assign w_full_hit     = baud_tick_in && (r_tick_cnt == FULL_LAST);
    assign w_par_exp      = (^r_shift) ^ (PARITY_ODD != 0);
    assign w_par_mismatch = r_rx_s ^ w_par_exp;

    // Frame FSM with registered outputs; pulses default low every cycle.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par_err  <= 1'b0;
            r_en       <= 1'b0;
            r_data     <= '0;
            r_valid    <= 1'b0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_perr  <= 1'b0;
            r_ferr  <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_en       <= 1'b1;
                    r_busy     <= 1'b0;
                    r_tick_cnt <= '0;
                    if (start_bit_in) begin
                        r_state   <= START;
                        r_en      <= 1'b0;
                        r_busy    <= 1'b1;
                        r_par_err <= 1'b0;
                    end
                end

                START: begin
                    if (w_half_hit) begin
                        r_tick_cnt <= '0;
                        if (!r_rx_s) begin
                            r_state   <= DATA;
                            r_bit_cnt <= '0;
                        end else begin
                            // Glitch rather than a real start bit.
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end else if (baud_tick_in) begin
                        r_tick_cnt <= r_tick_cnt + TW'(1);
                    end
                end

                DATA: begin
                    if (w_full_hit) begin
                        r_tick_cnt <= '0;
                        r_shift    <= {r_rx_s, r_shift[DATA_BITS-1:1]};
                        if (r_bit_cnt == BIT_LAST) begin
                            r_bit_cnt <= '0;
                            r_state   <= (PARITY_EN != 0) ? PARITY : STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + BW'(1);
                        end
                    end else if (baud_tick_in) begin
                        r_tick_cnt <= r_tick_cnt + TW'(1);
                    end
                end

                PARITY: begin
                    if (w_full_hit) begin
                        r_tick_cnt <= '0;
                        r_par_err  <= w_par_mismatch;
                        r_state    <= STOP;
                    end else if (baud_tick_in) begin
                        r_tick_cnt <= r_tick_cnt + TW'(1);
                    end
                end

                STOP: begin
                    if (w_full_hit) begin
                        r_tick_cnt <= '0;
                        if (r_rx_s) begin
                            r_data  <= r_shift;
                            r_valid <= 1'b1;
                            r_perr  <= r_par_err;
                            r_busy  <= 1'b0;
                            r_state <= IDLE;
                        end else begin
                            // Stop bit low: report and wait out a possible break.
                            r_ferr  <= 1'b1;
                            r_state <= BREAK_WAIT;
                        end
                    end else if (baud_tick_in) begin
                        r_tick_cnt <= r_tick_cnt + TW'(1);
                    end
                end

                BREAK_WAIT: begin
                    r_en <= 1'b0;
                    if (r_rx_s) begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_tick_cnt <= '0;
                    end
                end

                default: begin
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                    r_tick_cnt <= '0;
                end
            endcase
        end
    end

    assign startbit_det_enable_out = r_en;
    assign data_out                = r_data;
    assign data_valid_out          = r_valid;
    assign parity_err_out          = r_perr;
    assign framing_err_out         = r_ferr;
    assign busy_out                = r_busy;

endmodule

// File: tb/tb_uart_rx_frame_sampler.sv
// Bench for uart_rx_frame_sampler: an 8N1 instance and an 8E1 instance share
// clock, reset and baud tick. Expected results are queued per instance before
// each frame; a negedge monitor pops and compares on every output pulse.
module tb_uart_rx_frame_sampler;

    logic       Clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       baud_tick_in = 1'b0;
    logic       rx0 = 1'b1, st0 = 1'b0, rx1 = 1'b1, st1 = 1'b0;
    logic       en0, v0, pe0, fe0, b0;
    logic       en1, v1, pe1, fe1, b1;
    logic [7:0] d0, d1;

    always #5 Clk = ~Clk;

    uart_rx_frame_sampler #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(0), .PARITY_ODD(0)) u_dut0 (
        .Clk(Clk), .reset_n(reset_n), .baud_tick_in(baud_tick_in), .rx_in(rx0),
        .start_bit_in(st0), .startbit_det_enable_out(en0), .data_out(d0),
        .data_valid_out(v0), .parity_err_out(pe0), .framing_err_out(fe0), .busy_out(b0));

    uart_rx_frame_sampler #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
        .Clk(Clk), .reset_n(reset_n), .baud_tick_in(baud_tick_in), .rx_in(rx1),
        .start_bit_in(st1), .startbit_det_enable_out(en1), .data_out(d1),
        .data_valid_out(v1), .parity_err_out(pe1), .framing_err_out(fe1), .busy_out(b1));

    typedef struct {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic prev_tick = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every pulse must match the oldest queued expectation, and a
    // valid/error pulse must follow the cycle that carried the sampling tick.
    always @(negedge Clk) begin
        if (reset_n) begin
            if (v0 | pe0 | fe0) begin
                if (q0.size() == 0) check("dut0_unexpected_pulse", {29'd0, v0, pe0, fe0}, 32'd0);
                else begin
                    e0 = q0.pop_front();
                    check("dut0_valid", v0, !e0.ferr);
                    check("dut0_perr", pe0, e0.perr);
                    check("dut0_ferr", fe0, e0.ferr);
                    check("dut0_data", d0, e0.data);
                    check("dut0_latency", prev_tick, 1);
                end
            end
            if (v1 | pe1 | fe1) begin
                if (q1.size() == 0) check("dut1_unexpected_pulse", {29'd0, v1, pe1, fe1}, 32'd0);
                else begin
                    e1 = q1.pop_front();
                    check("dut1_valid", v1, !e1.ferr);
                    check("dut1_perr", pe1, e1.perr);
                    check("dut1_ferr", fe1, e1.ferr);
                    check("dut1_data", d1, e1.data);
                    check("dut1_latency", prev_tick, 1);
                end
            end
        end
        prev_tick = baud_tick_in;
    end

    task automatic clk1();
        @(posedge Clk);
        #1;
    endtask

    // One baud tick every 4 clocks, high for exactly one rising edge.
    task automatic ticks(input int n);
        repeat (n) begin
            baud_tick_in = 1'b1;
            clk1();
            baud_tick_in = 1'b0;
            repeat (3) clk1();
        end
    endtask

    task automatic set_rx(input int w, input logic v);
        if (w == 0) rx0 = v;
        else rx1 = v;
    endtask

    // Start-bit detector model: falling edge plus a one-clock start pulse.
    task automatic start_edge(input int w);
        set_rx(w, 1'b0);
        check("det_enable_before_start", (w == 0) ? en0 : en1, 1);
        if (w == 0) st0 = 1'b1;
        else st1 = 1'b1;
        clk1();
        st0 = 1'b0;
        st1 = 1'b0;
    endtask

    task automatic send_frame(input int w, input logic [7:0] d, input bit par_en,
                              input logic par, input logic stop, input int idle);
        start_edge(w);
        ticks(16);
        for (int i = 0; i < 8; i++) begin
            set_rx(w, d[i]);
            ticks(16);
        end
        if (par_en) begin
            set_rx(w, par);
            ticks(16);
        end
        set_rx(w, stop);
        ticks(16);
        for (int i = 0; i < idle; i++) begin
            set_rx(w, 1'b1);
            ticks(16);
        end
    endtask

    task automatic expect0(input logic [7:0] d, input logic pe, input logic fe);
        q0.push_back('{d, pe, fe});
    endtask

    task automatic expect1(input logic [7:0] d, input logic pe, input logic fe);
        q1.push_back('{d, pe, fe});
    endtask

    initial begin
        // Reset state and enable rising one clock after release.
        repeat (3) clk1();
        check("reset_outputs_dut0", {19'd0, en0, d0, v0, pe0, fe0, b0}, 32'd0);
        check("reset_outputs_dut1", {19'd0, en1, d1, v1, pe1, fe1, b1}, 32'd0);
        reset_n = 1'b1;
        check("enable_low_at_release", en0, 0);
        clk1();
        check("enable_after_first_clk", en0, 1);
        check("busy_idle", b0, 0);
        repeat (4) clk1();

        // 8N1 frame 0xA5.
        expect0(8'hA5, 1'b0, 1'b0);
        send_frame(0, 8'hA5, 0, 1'b0, 1'b1, 1);
        check("busy_after_A5", b0, 0);

        // False start: line low for 4 ticks only, back to IDLE on tick 8.
        start_edge(0);
        ticks(4);
        set_rx(0, 1'b1);
        ticks(3);
        check("busy_in_start", b0, 1);
        ticks(1);
        check("busy_after_false_start", b0, 0);
        check("enable_after_false_start", en0, 1);
        check("data_kept_after_false_start", d0, 8'hA5);
        ticks(8);

        // Frame 0x3C with low stop bit, then a 40-tick break.
        expect0(8'hA5, 1'b0, 1'b1);
        send_frame(0, 8'h3C, 0, 1'b0, 1'b0, 0);
        for (int k = 0; k < 40; k++) begin
            if (k % 10 == 0) begin
                st0 = 1'b1;
                clk1();
                st0 = 1'b0;
            end
            ticks(1);
        end
        check("busy_in_break", b0, 1);
        check("enable_low_in_break", en0, 0);
        set_rx(0, 1'b1);
        repeat (6) clk1();
        check("busy_after_break", b0, 0);
        check("enable_after_break", en0, 1);
        check("data_kept_after_break", d0, 8'hA5);
        ticks(16);

        // Even parity: 0x03 has even weight, so parity bit must be 0.
        expect1(8'h03, 1'b1, 1'b0);
        send_frame(1, 8'h03, 1, 1'b1, 1'b1, 1);
        expect1(8'h03, 1'b0, 1'b0);
        send_frame(1, 8'h03, 1, 1'b0, 1'b1, 1);
        // 0x07 has odd weight, so parity bit 1 is correct.
        expect1(8'h07, 1'b0, 1'b0);
        send_frame(1, 8'h07, 1, 1'b1, 1'b1, 1);

        // Reset after 4 data bits of 0xFF.
        start_edge(0);
        ticks(16);
        for (int i = 0; i < 4; i++) begin
            set_rx(0, 1'b1);
            ticks(16);
        end
        check("busy_mid_frame", b0, 1);
        reset_n = 1'b0;
        #1;
        check("async_reset_outputs", {19'd0, en0, d0, v0, pe0, fe0, b0}, 32'd0);
        set_rx(0, 1'b1);
        repeat (3) clk1();
        reset_n = 1'b1;
        clk1();
        check("enable_after_midframe_reset", en0, 1);
        repeat (4) clk1();
        expect0(8'h5A, 1'b0, 1'b0);
        send_frame(0, 8'h5A, 0, 1'b0, 1'b1, 1);

        // Back-to-back frames: next start edge half a bit after the stop sample.
        expect0(8'h00, 1'b0, 1'b0);
        send_frame(0, 8'h00, 0, 1'b0, 1'b1, 0);
        expect0(8'hFF, 1'b0, 1'b0);
        send_frame(0, 8'hFF, 0, 1'b0, 1'b1, 1);
        check("data_after_b2b", d0, 8'hFF);

        repeat (10) clk1();
        check("dut0_expectations_drained", q0.size(), 0);
        check("dut1_expectations_drained", q1.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame_sampler.md
Name: uart_rx_frame_sampler

Overview:
- Receiver stage directly downstream of the start-bit detector. It enables the detector while the line is idle and, on its start indication, takes over the serial line.
- Using a 16x oversampling baud tick, it samples each bit at mid-bit and assembles an LSB-first data word.
- It checks optional parity and the stop bit, then presents the received byte with a one-cycle valid pulse to the receive buffer/consumer.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..8)
OVERSAMPLE, 16, baud ticks per bit period (even, >=4)
PARITY_EN, 0, 1 = frame carries one parity bit after the data bits
PARITY_ODD, 0, 1 = odd parity, 0 = even parity (ignored when PARITY_EN=0)

Ports:
Clk  input  1  system clock, all logic on rising edge
reset_n  input  1  asynchronous reset, active low
baud_tick_in  input  1  one-Clk-wide strobe at OVERSAMPLE x baud rate
rx_in  input  1  raw serial line, idle high, asynchronous to Clk
start_bit_in  input  1  start indication from the start-bit detector
startbit_det_enable_out  output  1  enables the start-bit detector
data_out  output  DATA_BITS  last correctly framed data word
data_valid_out  output  1  one-Clk pulse when data_out is updated
parity_err_out  output  1  one-Clk pulse, coincident with data_valid_out, when parity mismatched
framing_err_out  output  1  one-Clk pulse when the stop bit is sampled low
busy_out  output  1  high in every state except IDLE

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; tick counter, bit counter and shift register cleared.
  - Two-flop rx synchroniser preset to 1.
  - Outputs: data_out=0, data_valid_out=0, parity_err_out=0, framing_err_out=0, busy_out=0, startbit_det_enable_out=0.
  - startbit_det_enable_out rises on the first Clk after reset release.
  - Reset mid-frame aborts the frame with no pulses.
- rx_in passes through the 2-flop synchroniser. All samples in this block use the synchronised value rx_s.
- Tick counter width is clog2(OVERSAMPLE). It advances only on baud_tick_in and is cleared on every state entry.
- IDLE:
  - startbit_det_enable_out=1.
  - start_bit_in=1 at a rising edge -> START, counter cleared, enable dropped the next cycle.
- START:
  - On the (OVERSAMPLE/2)th tick, sample rx_s.
  - rx_s=0 -> DATA.
  - rx_s=1 -> false start: back to IDLE, no pulses.
- DATA:
  - On every OVERSAMPLE-th tick, shift rx_s in at the MSB and shift right, so bit 0 arrives first.
  - After DATA_BITS samples -> PARITY if PARITY_EN, else STOP.
- PARITY:
  - On the OVERSAMPLE-th tick, sample rx_s.
  - Expected value = XOR of the data bits, inverted when PARITY_ODD.
  - Store the mismatch flag, then -> STOP.
- STOP: on the OVERSAMPLE-th tick, sample rx_s.
  - rx_s=1: next cycle, data_out<=shift register, data_valid_out=1, and parity_err_out=stored flag. Then -> IDLE.
  - rx_s=0: next cycle, framing_err_out=1. data_out is unchanged and there is no valid or parity pulse. Then -> BREAK_WAIT.
- BREAK_WAIT:
  - busy_out=1, detector disabled.
  - rx_s=1 on any Clk -> IDLE.
  - A held-low line (break) therefore never retriggers a start.
- Latency: data_valid_out is asserted exactly 1 Clk after the Clk carrying the stop-bit sampling tick.
- Pulse outputs are high for exactly one Clk, even if baud_tick_in is held high.
- start_bit_in is ignored outside IDLE.
- baud_tick_in coincident with a state transition is consumed by the transition and not counted.
- Back-to-back frames: start of the next frame is detected from IDLE one cycle after the valid pulse. A start edge one bit period after the stop-sample point must be received.

Test Plan:
- Frame 0xA5 (8N1, OVERSAMPLE=16) driven at ideal timing -> data_out=0xA5, data_valid_out high 1 Clk, 1 Clk after the stop-sample tick. No error pulses; busy_out low afterwards.
- rx_in low for 4 ticks only, with start_bit_in pulsed -> return to IDLE at tick 8. No pulses; data_out keeps its previous value; startbit_det_enable_out re-asserted.
- Frame 0x3C with the stop bit driven 0, line held low 40 ticks, then high:
  - framing_err_out pulses once and data_valid_out stays 0.
  - State stays in BREAK_WAIT until rx goes high, then IDLE.
  - No start is detected during the low period.
- PARITY_EN=1, PARITY_ODD=0, byte 0x03 with parity bit driven 1 -> data_out=0x03 and data_valid_out with parity_err_out both high in the same cycle. The same byte with parity 0 gives no parity_err_out.
- reset_n asserted after 4 data bits of 0xFF, released, then frame 0x5A sent:
  - All outputs go to 0 immediately on reset.
  - data_out=0x5A with a single valid pulse, and no residue from the aborted frame.
- Back-to-back frames 0x00 then 0xFF with minimum 1-bit idle -> two valid pulses, data_out=0x00 then 0xFF, no errors.
